// File: rtl/seven_seg_pkg.sv
// Shared segment encodings for the multiplexed 7-segment display path.
// Segments are active-low: bit7 = DP, bits 6..0 = g,f,e,d,c,b,a.
package seven_seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0     = 8'hC0;
  localparam seg_t SEG_1     = 8'hF9;
  localparam seg_t SEG_2     = 8'hA4;
  localparam seg_t SEG_3     = 8'hB0;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h92;
  localparam seg_t SEG_6     = 8'h82;
  localparam seg_t SEG_7     = 8'hF8;
  localparam seg_t SEG_8     = 8'h80;
  localparam seg_t SEG_9     = 8'h90;
  localparam seg_t SEG_A     = 8'h88;
  localparam seg_t SEG_B     = 8'h83;
  localparam seg_t SEG_C     = 8'hC6;
  localparam seg_t SEG_D     = 8'hA1;
  localparam seg_t SEG_E     = 8'h86;
  localparam seg_t SEG_F     = 8'h8E;
  localparam seg_t SEG_DASH  = 8'hBF;
  localparam seg_t SEG_BLANK = 8'hFF;

  // DP is active-low like the other segments, so a lit DP clears bit7.
  function automatic seg_t seg_with_dp(input seg_t glyph, input logic dp);
    return {~dp & glyph[7], glyph[6:0]};
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Nibble to active-low segment pattern, with hex/dash selection,
// leading-zero blanking and an independent decimal point.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       dp,
  input  logic       suppress,
  output seg_t       seg
);

  seg_t glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (nibble)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA:    glyph = hex_mode ? SEG_A : SEG_DASH;
      4'hB:    glyph = hex_mode ? SEG_B : SEG_DASH;
      4'hC:    glyph = hex_mode ? SEG_C : SEG_DASH;
      4'hD:    glyph = hex_mode ? SEG_D : SEG_DASH;
      4'hE:    glyph = hex_mode ? SEG_E : SEG_DASH;
      4'hF:    glyph = hex_mode ? SEG_F : SEG_DASH;
      default: glyph = SEG_BLANK;
    endcase
  end

  // A suppressed leading zero still honours its decimal point.
  assign seg = seg_with_dp(suppress ? SEG_BLANK : glyph, dp);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode display driver: slot timer, digit scan,
// frame-aligned double buffering and registered segment/digit outputs.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
  input  logic                    load,
  output seg_t                    segments,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam cnt_t CNT_TOP  = cnt_t'(SCAN_DIV - 1);
  localparam idx_t IDX_LAST = idx_t'(NUM_DIGITS - 1);
  // Down-counter equivalent of "slot position < BLANK_CYC".
  localparam cnt_t BLANK_TH = (BLANK_CYC > 0) ? cnt_t'(SCAN_DIV - BLANK_CYC) : cnt_t'(0);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seven_seg_scanner: NUM_DIGITS must be 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seven_seg_scanner: SCAN_DIV must be at least 2");
  end
  if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
    $error("seven_seg_scanner: BLANK_CYC must be below SCAN_DIV");
  end

  cnt_t cnt;
  idx_t idx;
  logic slot_end;
  logic frame_end;
  logic in_blank;

  logic [4*NUM_DIGITS-1:0] pend_value, disp_value;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    pend_hex, disp_hex;
  logic                    pend_lz, disp_lz;
  logic                    pend_valid;

  logic [NUM_DIGITS-1:0] supp;
  logic [NUM_DIGITS-1:0] sel_n;
  logic                  lead_zero;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_supp;
  seg_t                  dec_seg;

  assign slot_end  = (cnt == '0);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_blank  = (BLANK_CYC > 0) && (cnt >= BLANK_TH);

  // Slot timer counts down from SCAN_DIV-1; terminal count advances the digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= CNT_TOP;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= CNT_TOP;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_hex   <= 1'b0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_hex   <= 1'b0;
      disp_lz    <= 1'b0;
    end else if (load && frame_end) begin
      // Boundary-coincident load bypasses the pending stage.
      disp_value <= value;
      disp_dp    <= dp_mask;
      disp_hex   <= hex_mode;
      disp_lz    <= lz_suppress;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp_mask;
      pend_hex   <= hex_mode;
      pend_lz    <= lz_suppress;
      pend_valid <= 1'b1;
    end else if (frame_end && pend_valid) begin
      disp_value <= pend_value;
      disp_dp    <= pend_dp;
      disp_hex   <= pend_hex;
      disp_lz    <= pend_lz;
      pend_valid <= 1'b0;
    end
  end

  always_comb begin
    supp      = '0;
    sel_n     = '1;
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_supp  = 1'b0;
    lead_zero = disp_lz;
    // A digit is a leading zero only if it and every digit above it are zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead_zero = lead_zero && (disp_value[4*k +: 4] == 4'h0);
      supp[k]   = lead_zero && (k != 0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == idx_t'(k)) begin
        sel_nib  = disp_value[4*k +: 4];
        sel_dp   = disp_dp[k];
        sel_supp = supp[k];
        sel_n[k] = 1'b0;
      end
    end
  end

  seven_seg_decoder u_decoder (
    .nibble   (sel_nib),
    .hex_mode (disp_hex),
    .dp       (sel_dp),
    .suppress (sel_supp),
    .seg      (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      segments   <= SEG_BLANK;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (in_blank) begin
        segments  <= SEG_BLANK;
        digit_sel <= '1;
      end else begin
        segments  <= dec_seg;
        digit_sel <= sel_n;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: stimulus queues the expected per-digit segments of each
// frame; a monitor rebuilds each scanned frame and compares on frame_done.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        hex_mode = 1'b0;
  logic        lz_suppress = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  segments;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Expected frame: {digit3, digit2, digit1, digit0} segment bytes.
  logic [31:0] exp_q [$];

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_mask     (dp_mask),
    .hex_mode    (hex_mode),
    .lz_suppress (lz_suppress),
    .load        (load),
    .segments    (segments),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  logic [7:0] m_got [4];
  int         m_lit [4];
  int         m_last;
  bit         m_ok;
  int         m_since;
  bit         m_have_prev;
  int         m_d;
  logic [31:0] m_exp;

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      m_got[i] = 8'h00;
      m_lit[i] = 0;
    end
    m_last = -1;
    m_ok   = 1'b1;
  endtask

  initial begin : monitor
    m_clear();
    m_since = 0;
    m_have_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        m_clear();
        m_since = 0;
        m_have_prev = 1'b0;
      end else begin
        m_since++;
        case (digit_sel)
          4'hE: m_d = 0;
          4'hD: m_d = 1;
          4'hB: m_d = 2;
          4'h7: m_d = 3;
          4'hF: m_d = -1;
          default: begin
            m_d = -2;
            m_ok = 1'b0;
          end
        endcase
        if (m_d == -1 && segments !== 8'hFF) m_ok = 1'b0;
        if (m_d >= 0) begin
          if (m_d != m_last) begin
            if (m_d != m_last + 1) m_ok = 1'b0;
            m_last = m_d;
            m_got[m_d] = segments;
            m_lit[m_d] = 1;
          end else begin
            if (m_got[m_d] !== segments) m_ok = 1'b0;
            m_lit[m_d]++;
          end
        end
        if (frame_done === 1'b1) begin
          if (m_have_prev) begin
            checks++;
            if (m_since != 32) begin
              errors++;
              $display("FAIL frame_period: got %0d cycles, expected 32", m_since);
            end
          end
          m_have_prev = 1'b1;
          m_since = 0;
          for (int i = 0; i < 4; i++) if (m_lit[i] != 6) m_ok = 1'b0;
          checks++;
          if (!m_ok) begin
            errors++;
            $display("FAIL frame_structure: lit counts %0d %0d %0d %0d, expected 6 each, in order, blanks FF",
                     m_lit[0], m_lit[1], m_lit[2], m_lit[3]);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: frame completed with no expected entry");
          end else begin
            m_exp = exp_q.pop_front();
            for (int i = 0; i < 4; i++) begin
              checks++;
              if (m_got[i] !== m_exp[8*i +: 8]) begin
                errors++;
                $display("FAIL frame_digit%0d: got %h, expected %h", i, m_got[i], m_exp[8*i +: 8]);
              end
            end
          end
          m_clear();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_frame();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL frame_timeout: frame_done 0 for 200 cycles, expected a pulse");
  endtask

  task automatic frame(input logic [31:0] e);
    exp_q.push_back(e);
    wait_frame();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp,
                         input logic hx, input logic lz);
    value = v;
    dp_mask = dp;
    hex_mode = hx;
    lz_suppress = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check_val("reset_segments", segments, 8'hFF);
    check_val("reset_digit_sel", {4'h0, digit_sel}, 8'h0F);
    check_val("reset_frame_done", {7'h0, frame_done}, 8'h00);
    exp_q.push_back(32'hC0C0C0C0);
    reset = 1'b0;
    wait_frame();
    frame(32'hC0C0C0C0);

    // hex mode with a decimal point; current frame keeps the old value
    do_load(16'h12AF, 4'b0100, 1'b1, 1'b0);
    frame(32'hC0C0C0C0);
    frame(32'hF924888E);

    do_load(16'h12AF, 4'b0000, 1'b0, 1'b0);
    frame(32'hF924888E);
    frame(32'hF9A4BFBF);

    // leading-zero suppression
    do_load(16'h0050, 4'b0000, 1'b0, 1'b1);
    frame(32'hF9A4BFBF);
    frame(32'hFFFF92C0);
    do_load(16'h0000, 4'b0000, 1'b0, 1'b1);
    frame(32'hFFFF92C0);
    frame(32'hFFFFFFC0);
    do_load(16'h0000, 4'b1000, 1'b0, 1'b1);
    frame(32'hFFFFFFC0);
    frame(32'h7FFFFFC0);
    do_load(16'h0B0C, 4'b0001, 1'b1, 1'b1);
    frame(32'h7FFFFFC0);
    frame(32'hFF83C046);

    // two loads in one frame: last wins
    do_load(16'h1111, 4'b0000, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    do_load(16'h2222, 4'b0000, 1'b0, 1'b0);
    frame(32'hFF83C046);
    frame(32'hA4A4A4A4);

    // load coinciding with the frame boundary (state cycle 31)
    exp_q.push_back(32'hA4A4A4A4);
    repeat (31) @(negedge clk);
    value = 16'h3456;
    dp_mask = 4'b0000;
    hex_mode = 1'b0;
    lz_suppress = 1'b0;
    load = 1'b1;
    wait_frame();
    load = 1'b0;
    frame(32'hB0999282);
    frame(32'hB0999282);

    // reset at idx=2, p=5 with a pending load outstanding
    do_load(16'h9999, 4'b1111, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("midreset_segments", segments, 8'hFF);
    check_val("midreset_digit_sel", {4'h0, digit_sel}, 8'h0F);
    check_val("midreset_frame_done", {7'h0, frame_done}, 8'h00);
    exp_q.push_back(32'hC0C0C0C0);
    reset = 1'b0;
    wait_frame();
    frame(32'hC0C0C0C0);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_frames: got %0d unconsumed, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
